// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer for a shared ALU; define ALU_ARB_STATS_EN for per-requester grant counters
module alu_arbiter #(
   parameter int DATA_W = 8,
   parameter int OP_W = 3,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
`ifdef ALU_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1,
`endif
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [OP_W-1:0]   req1_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [OP_W-1:0]   alu_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [DATA_W-1:0] resp_result,
   output logic [3:0]        resp_flags
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nxt;
   logic rr_ptr, grant_vld, grant_id;
   // grant only in IDLE; the granted requester is valid by construction, so a grant is an accept
   always_comb begin
      grant_vld = state == IDLE && (req0_valid || req1_valid) && !rst;
      grant_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
      req0_ready = grant_vld && !grant_id;
      req1_ready = grant_vld && grant_id;
      state_nxt = state == IDLE ? (grant_vld ? EXEC : IDLE) :
                  state == EXEC ? RESP : (resp_ready ? IDLE : RESP);
   end
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nxt;
   end
   // operand latch on accept, result capture after the single EXEC cycle, response handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 1'b0;
         alu_a <= '0;
         alu_b <= '0;
         alu_opcode <= '0;
         resp_valid <= 1'b0;
         resp_id <= 1'b0;
         resp_result <= '0;
         resp_flags <= '0;
      end else begin
         if (grant_vld) begin
            alu_a <= grant_id ? req1_a : req0_a;
            alu_b <= grant_id ? req1_b : req0_b;
            alu_opcode <= grant_id ? req1_op : req0_op;
            resp_id <= grant_id;
            rr_ptr <= !grant_id;
         end
         if (state == EXEC) begin
            resp_result <= alu_result;
            resp_flags <= alu_flags;
            resp_valid <= 1'b1;
         end
         if (state == RESP && resp_ready) resp_valid <= 1'b0;
      end
   end
`ifdef ALU_ARB_STATS_EN
   // saturating grant counters; a clear beats a simultaneous accept
   always_ff @(posedge clk) begin
      if (rst || stats_clr) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (grant_vld && !grant_id && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         if (grant_vld && grant_id && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
   end
`else
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = '0;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed bench for alu_arbiter with a behavioural ALU and transaction model
module tb_alu_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
   logic req0_ready, req1_ready, resp_valid, resp_id;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic [7:0] alu_a, alu_b, alu_result, resp_result;
   logic [2:0] alu_opcode;
   logic [3:0] alu_flags, resp_flags;
   int tests = 0, fails = 0;
`ifdef ALU_ARB_STATS_EN
   logic stats_clr = 1'b0;
   logic [1:0] grant_cnt0, grant_cnt1;
`endif
   alu_arbiter #(.DATA_W(8), .OP_W(3), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
`ifdef ALU_ARB_STATS_EN
      .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_flags(alu_flags),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_flags(resp_flags)
   );
   always #5 clk = ~clk;
   // ALU reference: returns {result, carry, zero, overflow, negative}
   function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic c, o;
      c = 1'b0;
      o = 1'b0;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
         3'd1: r = a - b;
         3'd2: r = a + 8'd1;
         3'd3: r = a - 8'd1;
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = ~a;
      endcase
      return {r, c, r == 8'd0, o, r[7]};
   endfunction
   assign {alu_result, alu_flags} = alu_f(alu_opcode, alu_a, alu_b);

   task automatic idle_inputs;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({req1_ready, req0_ready} !== 2'b00) begin fails++; $display("FAIL reset_ready got=%b want=00", {req1_ready, req0_ready}); end
      tests++;
      if ({alu_a, alu_b, alu_opcode} !== 19'd0) begin fails++; $display("FAIL reset_alu got=%h/%h/%h want=0", alu_a, alu_b, alu_opcode); end
      tests++;
      if ({resp_valid, resp_id, resp_result, resp_flags} !== 14'd0)
         begin fails++; $display("FAIL reset_resp got=%b/%b/%h/%b want=0", resp_valid, resp_id, resp_result, resp_flags); end
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single(input string name, input logic id, input logic [2:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
      resp_ready = 1'b1;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
      else begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      tests++;
      if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01))
         begin fails++; $display("FAIL %s_ready got=%b want=%b", name, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01); end
      @(negedge clk);
      idle_inputs();
      #1;
      tests++;
      if (resp_valid !== 1'b0 || {alu_opcode, alu_a, alu_b} !== {op, a, b})
         begin fails++; $display("FAIL %s_exec got=%b %h/%h/%h want=0 %h/%h/%h", name, resp_valid, alu_opcode, alu_a, alu_b, op, a, b); end
      @(negedge clk);
      #1;
      tests++;
      if ({resp_valid, resp_id, resp_result, resp_flags} !== {1'b1, id, er, ef})
         begin fails++; $display("FAIL %s_resp got=%b/%b/%h/%b want=1/%b/%h/%b", name, resp_valid, resp_id, resp_result, resp_flags, id, er, ef); end
      @(negedge clk);
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL %s_done got=%b want=0", name, resp_valid); end
   endtask

   task automatic test_round_robin;
      int acc_n, rsp_n, last;
      acc_n = 0; rsp_n = 0; last = 0;
      req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 3'd4;
      req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h0F; req1_op = 3'd6;
      resp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         if (req0_ready || req1_ready) begin
            tests++;
            if ({req1_ready, req0_ready} !== ((acc_n % 2) ? 2'b10 : 2'b01))
               begin fails++; $display("FAIL rr_grant%0d got=%b want=%b", acc_n, {req1_ready, req0_ready}, (acc_n % 2) ? 2'b10 : 2'b01); end
            if (acc_n > 0) begin
               tests++;
               if (c - last != 3) begin fails++; $display("FAIL rr_spacing got=%0d want=3", c - last); end
            end
            last = c;
            acc_n++;
         end
         if (resp_valid) begin
            tests++;
            if ({resp_id, resp_result} !== ((rsp_n % 2) ? {1'b1, 8'hF0} : {1'b0, 8'h30}))
               begin fails++; $display("FAIL rr_resp%0d got=%b/%h", rsp_n, resp_id, resp_result); end
            rsp_n++;
         end
      end
      tests++;
      if (acc_n != 4 || rsp_n != 4) begin fails++; $display("FAIL rr_count got=%0d/%0d want=4/4", acc_n, rsp_n); end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      req1_valid = 1'b1; req1_a = 8'h5A; req1_b = 8'h81; req1_op = 3'd5; resp_ready = 1'b0;
      @(negedge clk);
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         tests++;
         if ({resp_valid, resp_id, resp_result, resp_flags, req1_ready, req0_ready} !== {1'b1, 1'b1, 8'hDB, 4'b0001, 2'b00})
            begin fails++; $display("FAIL bp_hold%0d got=%b/%b/%h/%b rdy=%b want=1/1/db/0001 rdy=00",
                                     k, resp_valid, resp_id, resp_result, resp_flags, {req1_ready, req0_ready}); end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if ({resp_valid, req0_ready} !== 2'b01) begin fails++; $display("FAIL bp_release got=%b want=01", {resp_valid, req0_ready}); end
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL bp_drop got=%b want=0", resp_valid); end
   endtask

   task automatic test_reset_mid;
      req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h00; req0_op = 3'd2; resp_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if ({resp_valid, resp_id, resp_result, resp_flags, alu_a, alu_b, alu_opcode, req0_ready, req1_ready} !== 35'd0)
         begin fails++; $display("FAIL rstmid_outputs got=%b/%h/%h/%h want=0", resp_valid, resp_result, alu_a, alu_opcode); end
      rst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      tests++;
      if ({req1_ready, req0_ready} !== 2'b01) begin fails++; $display("FAIL rstmid_grant got=%b want=01", {req1_ready, req0_ready}); end
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if (resp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_noresp got=%b want=0", resp_valid); end
   endtask

   task automatic test_random;
      bit busy, prio, e_id, any, want_id, rv;
      int acc_c;
      logic [11:0] e_rf;
      busy = 0; prio = 0; e_id = 0; acc_c = 0; e_rf = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         req0_valid = ($urandom_range(0, 2) != 0); req1_valid = ($urandom_range(0, 2) != 0);
         req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
         req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         #1;
         any = !busy && (req0_valid || req1_valid);
         want_id = (req0_valid && req1_valid) ? prio : req1_valid;
         tests++;
         if ({req1_ready, req0_ready} !== (any ? (want_id ? 2'b10 : 2'b01) : 2'b00))
            begin fails++; $display("FAIL rnd_ready c=%0d got=%b want_any=%b id=%b", c, {req1_ready, req0_ready}, any, want_id); end
         rv = busy && c >= acc_c + 2;
         tests++;
         if (resp_valid !== rv) begin fails++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, resp_valid, rv); end
         if (rv) begin
            tests++;
            if ({resp_id, resp_result, resp_flags} !== {e_id, e_rf})
               begin fails++; $display("FAIL rnd_resp c=%0d got=%b/%h/%b want=%b/%h/%b", c, resp_id, resp_result, resp_flags, e_id, e_rf[11:4], e_rf[3:0]); end
         end
         if (any) begin
            busy = 1; acc_c = c; e_id = want_id; prio = !want_id;
            e_rf = want_id ? alu_f(req1_op, req1_a, req1_b) : alu_f(req0_op, req0_a, req0_b);
         end else if (rv && resp_ready) busy = 0;
      end
      @(negedge clk);
      idle_inputs();
      resp_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats;
      stats_clr = 1'b1;
      @(negedge clk);
      stats_clr = 1'b0;
      #1;
      tests++;
      if ({grant_cnt0, grant_cnt1} !== 4'd0) begin fails++; $display("FAIL stats_clr_idle got=%0d/%0d want=0/0", grant_cnt0, grant_cnt1); end
      resp_ready = 1'b1;
      req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'd0;
      for (int k = 0; k < 5; k++) begin
         req0_valid = 1'b1;
         @(negedge clk);
         req0_valid = 1'b0;
         #1;
         tests++;
         if (grant_cnt0 !== 2'((k < 3) ? k + 1 : 3)) begin fails++; $display("FAIL stats_cnt%0d got=%0d want=%0d", k, grant_cnt0, (k < 3) ? k + 1 : 3); end
         repeat (2) @(negedge clk);
      end
      req0_valid = 1'b1;
      stats_clr = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      stats_clr = 1'b0;
      #1;
      tests++;
      if (grant_cnt0 !== 2'd0) begin fails++; $display("FAIL stats_clr_accept got=%0d want=0", grant_cnt0); end
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_single("add_ovf", 1'b0, 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011);
      test_single("sub_zero", 1'b1, 3'd1, 8'h05, 8'h05, 8'h00, 4'b0100);
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 8-bit combinational ALU (opcode set ADD/SUB/INC/DEC/AND/OR/XOR/NOT).
- Accepts operations over valid/ready handshakes and grants round-robin.
- Registers operands onto the ALU input bus and captures result and flags.
- Returns each result, tagged with the requester ID, through a back-pressurable response port.
- Sits between the instruction-issue logic and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
DATA_W, 8, operand/result width; must match the ALU width.
OP_W, 3, opcode width.
CNT_W, 16, width of grant counters (used only with the optional feature).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req0_valid / req1_valid  in  1  requester 0/1 has an operation
req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle
req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
req0_op / req1_op  in  OP_W  opcode
alu_a, alu_b  out  DATA_W  registered ALU operands
alu_opcode  out  OP_W  registered ALU opcode
alu_result  in  DATA_W  ALU result (combinational from alu_*)
alu_flags  in  4  {carry_out, zero, overflow, negative} from the ALU
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  1  requester that issued the operation
resp_result  out  DATA_W  captured result
resp_flags  out  4  captured {carry, zero, overflow, negative}

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (synchronous, rst=1 at posedge) forces the following:
  - state=IDLE, rr_ptr=0.
  - alu_a=alu_b=0, alu_opcode=0.
  - resp_valid=0, resp_id=0, resp_result=0, resp_flags=0.
  - Both req*_ready=0 while rst is high.
- Grant (combinational, IDLE only):
  - Only one valid: that requester is granted.
  - Both valid: requester rr_ptr is granted.
  - No valid: no grant.
- reqN_ready = (state==IDLE) && grant==N && !rst. At most one ready is high per cycle.
- Accept cycle (IDLE, reqN_valid && reqN_ready):
  - Latch reqN_a/b/op into alu_a/alu_b/alu_opcode and N into resp_id.
  - rr_ptr <= ~N, i.e. the other requester has priority next time.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU output settles combinationally.
  - At the clock edge: resp_result<=alu_result, resp_flags<=alu_flags, resp_valid<=1, go to RESP.
- RESP:
  - Hold resp_* stable while resp_valid && !resp_ready.
  - On resp_ready: resp_valid<=0, go to IDLE.
  - No new accept in the same cycle as the response handshake.
- Latency: accept at edge N, resp_valid high from edge N+2. Minimum issue interval is 3 cycles.
- alu_a/alu_b/alu_opcode hold their last values outside EXEC; the ALU sees no glitching operands.
- Operand values are passed unmodified; all arithmetic and flag semantics belong to the ALU. The flags meaning is fixed: carry and overflow are non-zero only for ADD.
- A requester dropping valid before ready is legal; no grant is recorded and rr_ptr is unchanged.
- Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is produced, and the next grant goes to requester 0.

Optional Feature:
Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (CNT_W each).
  - Each counter increments on every accept from its requester and saturates at all-ones (no wrap).
  - Both counters clear on rst.
  - Adds input stats_clr (1 bit), which zeroes both counters synchronously. If stats_clr and an accept occur in the same cycle, the clear wins and the counter reads 0.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 ADD a=0x7F b=0x01 with resp_ready=1 -> req0_ready at cycle 0, resp_valid at +2, resp_id=0, result=0x80, flags carry=0 zero=0 overflow=1 negative=1.
- req1 SUB a=0x05 b=0x05 -> result=0x00, zero=1, carry=0, overflow=0, resp_id=1.
- Both valid continuously after reset (req0 AND 0xF0&0x3C, req1 XOR 0xFF^0x0F) -> grant order 0,1,0,1; results 0x30 and 0xF0 alternate with matching resp_id; accepts exactly 3 cycles apart.
- resp_ready held low 5 cycles after resp_valid -> resp_result, resp_flags and resp_id stable, both req*_ready=0; the response completes on the first cycle resp_ready=1.
- rst asserted during EXEC of an INC on 0xFF -> no resp_valid, all outputs at reset values; next simultaneous request is granted to requester 0.
- With ALU_ARB_STATS_EN and CNT_W=2: 5 accepts from req0 -> grant_cnt0 reads 1,2,3,3,3. Asserting stats_clr on an accept cycle -> grant_cnt0=0.
